// File: rtl/instr_packer_pkg.sv
// Shared widths and field layout of the 105-bit accelerator instruction, plus the word-to-instruction packing helper.
// Used by the packer on the host side and by anything decoding the instruction downstream.
package instr_packer_pkg;

   localparam int INSTR_BITS      = 105;
   localparam int HOST_WORD_BITS  = 32;
   localparam int WORD_ADDR_BITS  = 10;
   localparam int DATA_MAX_BITS   = 8;
   localparam int LAST_WORD_BITS  = INSTR_BITS - 3 * HOST_WORD_BITS;

   // MSB-first: op occupies [104:102], B_col occupies [7:0]
   typedef struct packed {
      logic [2:0]                op;
      logic [WORD_ADDR_BITS-1:0] wb_addr;
      logic [DATA_MAX_BITS-1:0]  wb_ch;
      logic [DATA_MAX_BITS-1:0]  wb_row;
      logic [DATA_MAX_BITS-1:0]  wb_col;
      logic [WORD_ADDR_BITS-1:0] a_addr;
      logic [DATA_MAX_BITS-1:0]  a_ch;
      logic [DATA_MAX_BITS-1:0]  a_row;
      logic [DATA_MAX_BITS-1:0]  a_col;
      logic [WORD_ADDR_BITS-1:0] b_addr;
      logic [DATA_MAX_BITS-1:0]  b_ch;
      logic [DATA_MAX_BITS-1:0]  b_row;
      logic [DATA_MAX_BITS-1:0]  b_col;
   } instr_t;

   function automatic instr_t pack_words(input logic [LAST_WORD_BITS-1:0] w3,
                                         input logic [HOST_WORD_BITS-1:0] w2,
                                         input logic [HOST_WORD_BITS-1:0] w1,
                                         input logic [HOST_WORD_BITS-1:0] w0);
      return instr_t'({w3, w2, w1, w0});
   endfunction

endpackage

// File: rtl/instr_packer_fifo.sv
// Synchronous FIFO with clear; push is ignored when full, pop ignored when empty, clear overrides both.
// Head visible one cycle after push (no bypass); head reads zero when empty.
module instr_fifo #(
   parameter int WIDTH = 105,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full && !i_clr;
   assign w_pop   = i_pop && !o_empty && !i_clr;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count    = r_count;

endmodule

// File: rtl/instr_packer.sv
// Assembles four 32-bit host words into one instruction and queues it for the decoder; push on word3, valid 1 cycle later.
// Host stalls only on word3 while the queue is full; wr_ready is purely registered state.
module instr_packer
   import instr_packer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [HOST_WORD_BITS-1:0] wr_data,
   output logic                      wr_ready,
   input  logic                      flush,
   output logic                      instr_valid,
   output logic [INSTR_BITS-1:0]     instr,
   input  logic                      instr_ready,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      busy
);

   logic [1:0]                r_word_cnt;
   logic [HOST_WORD_BITS-1:0] r_w0;
   logic [HOST_WORD_BITS-1:0] r_w1;
   logic [HOST_WORD_BITS-1:0] r_w2;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_accept;
   logic                      w_push;
   logic                      w_pop;
   instr_t                    w_push_instr;

   assign wr_ready     = !((r_word_cnt == 2'd3) && w_full);
   assign w_accept     = wr_en && wr_ready && !flush;
   assign w_push       = w_accept && (r_word_cnt == 2'd3);
   assign w_pop        = instr_valid && instr_ready;
   assign w_push_instr = pack_words(wr_data[LAST_WORD_BITS-1:0], r_w2, r_w1, r_w0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_cnt <= 2'd0;
         r_w0       <= '0;
         r_w1       <= '0;
         r_w2       <= '0;
      end else if (flush) begin
         r_word_cnt <= 2'd0;
      end else if (w_accept) begin
         r_word_cnt <= r_word_cnt + 2'd1;
         case (r_word_cnt)
            2'd0:    r_w0 <= wr_data;
            2'd1:    r_w1 <= wr_data;
            2'd2:    r_w2 <= wr_data;
            default: ;
         endcase
      end
   end

   instr_fifo #(
      .WIDTH (INSTR_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (flush),
      .i_push     (w_push),
      .i_push_dat (w_push_instr),
      .i_pop      (w_pop),
      .o_head_dat (instr),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (fifo_count)
   );

   assign instr_valid = !w_empty;
   assign busy        = (r_word_cnt != 2'd0) || !w_empty;

endmodule

// File: tb/tb_instr_packer.sv
// Directed and randomized checks of word assembly, queue ordering, backpressure, flush and async reset.
module tb_instr_packer;

   localparam int DEPTH = 4;
   localparam int N6    = 24;

   logic         clk;
   logic         rst_n;
   logic         wr_en;
   logic [31:0]  wr_data;
   logic         wr_ready;
   logic         flush;
   logic         instr_valid;
   logic [104:0] instr;
   logic         instr_ready;
   logic [2:0]   fifo_count;
   logic         busy;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct packed {
      logic [2:0] op;
      logic [9:0] wb_addr; logic [7:0] wb_ch; logic [7:0] wb_row; logic [7:0] wb_col;
      logic [9:0] a_addr;  logic [7:0] a_ch;  logic [7:0] a_row;  logic [7:0] a_col;
      logic [9:0] b_addr;  logic [7:0] b_ch;  logic [7:0] b_row;  logic [7:0] b_col;
   } tb_fields_t;

   typedef struct {
      logic [3:0][31:0] w;
      logic [104:0]     exp;
   } vec_t;

   vec_t vt [4];

   instr_packer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .flush       (flush),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .fifo_count  (fifo_count),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [104:0] act, input logic [104:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [104:0] words2instr(input logic [3:0][31:0] w);
      return {w[3][8:0], w[2], w[1], w[0]};
   endfunction

   function automatic logic [3:0][31:0] wk(input int k);
      logic [3:0][31:0] w;
      w[0] = 32'h1000_0000 + 32'(k);
      w[1] = 32'h2000_0000 + 32'(k);
      w[2] = 32'h3000_0000 + 32'(k);
      w[3] = 32'hFFFF_FE00 | 32'(k);
      return w;
   endfunction

   // Called at a negedge; returns at the negedge after the word was accepted
   task automatic put_word(input logic [31:0] d);
      int t;
      t = 0;
      wr_en   = 1'b1;
      wr_data = d;
      while (!wr_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_vec++;
         n_miss++;
         $display("FAIL wr_ready_timeout: got 0 expected 1");
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic put_instr(input logic [3:0][31:0] w);
      for (int i = 0; i < 4; i++) put_word(w[i]);
   endtask

   task automatic pop_one();
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
   endtask

   task automatic writer6(input logic [3:0][31:0] ws [N6]);
      for (int j = 0; j < N6; j++) put_instr(ws[j]);
   endtask

   initial begin
      tb_fields_t       ef [N6];
      logic [3:0][31:0] ws [N6];
      logic [127:0]     rnd;
      logic [31:0]      junk;

      vt[0].w = {32'h0000_01A0, 32'h0, 32'h0, 32'h0000_0008};
      vt[0].exp = 105'h1A0_00000000_00000000_00000008;
      vt[1].w = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vt[1].exp = 105'h1FF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      vt[2].w = {32'hFFFF_FE00, 32'h0F1E_2D3C, 32'h9ABC_DEF0, 32'h1234_5678};
      vt[2].exp = 105'h000_0F1E2D3C_9ABCDEF0_12345678;
      vt[3].w = {32'h0000_0155, 32'hC3C3_C3C3, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
      vt[3].exp = 105'h155_C3C3C3C3_5A5A5A5A_A5A5A5A5;

      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // table vectors: assembly and layout
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 3; j++) put_word(vt[i].w[j]);
         chk("vec_partial_busy", busy, 1);
         chk("vec_partial_valid", instr_valid, 0);
         put_word(vt[i].w[3]);
         chk("vec_valid", instr_valid, 1);
         chk("vec_instr", instr, vt[i].exp);
         chk("vec_count", fifo_count, 1);
         if (i == 0) begin
            chk("t1_op", instr[104:102], 3'b110);
            chk("t1_b_col", instr[7:0], 8'h08);
         end
         pop_one();
         chk("vec_pop_valid", instr_valid, 0);
         chk("vec_pop_instr", instr, 0);
         chk("vec_pop_busy", busy, 0);
      end

      // T2: fill, stall on word3, release by one pop
      for (int k = 1; k <= 4; k++) put_instr(wk(k));
      chk("t2_count_full", fifo_count, 4);
      chk("t2_ready_wc0", wr_ready, 1);
      for (int j = 0; j < 3; j++) put_word(wk(5)[j]);
      chk("t2_ready_stall", wr_ready, 0);
      wr_en = 1'b1; wr_data = wk(5)[3];
      @(negedge clk);
      chk("t2_no_push", fifo_count, 4);
      chk("t2_head1", instr, words2instr(wk(1)));
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      chk("t2_ready_back", wr_ready, 1);
      chk("t2_count_after_pop", fifo_count, 3);
      @(negedge clk);
      wr_en = 1'b0;
      chk("t2_count_refill", fifo_count, 4);
      for (int k = 2; k <= 5; k++) begin
         chk("t2_order", instr, words2instr(wk(k)));
         pop_one();
      end
      chk("t2_drained", instr_valid, 0);

      // T3: simultaneous push and pop at count 1
      put_instr(wk(6));
      for (int j = 0; j < 3; j++) put_word(wk(7)[j]);
      chk("t3_count_pre", fifo_count, 1);
      wr_en = 1'b1; wr_data = wk(7)[3]; instr_ready = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; instr_ready = 1'b0;
      chk("t3_count", fifo_count, 1);
      chk("t3_head", instr, words2instr(wk(7)));
      pop_one();

      // T4: flush overrides write and pop
      put_instr(wk(8));
      put_instr(wk(9));
      put_word(wk(10)[0]);
      put_word(wk(10)[1]);
      flush = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; instr_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; wr_en = 1'b0; instr_ready = 1'b0;
      chk("t4_count", fifo_count, 0);
      chk("t4_valid", instr_valid, 0);
      chk("t4_busy", busy, 0);
      put_instr(wk(11));
      chk("t4_clean", instr, words2instr(wk(11)));
      chk("t4_count_after", fifo_count, 1);
      pop_one();

      // T5: asynchronous reset mid-sequence
      for (int k = 12; k <= 14; k++) put_instr(wk(k));
      put_word(wk(15)[0]);
      put_word(wk(15)[1]);
      chk("t5_count_pre", fifo_count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_valid", instr_valid, 0);
      chk("t5_instr", instr, 0);
      chk("t5_count", fifo_count, 0);
      chk("t5_busy", busy, 0);
      chk("t5_wr_ready", wr_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_stale", instr_valid, 0);
      put_instr(wk(16));
      chk("t5_clean", instr, words2instr(wk(16)));
      pop_one();

      // T6: random fields, random consumer backpressure
      for (int j = 0; j < N6; j++) begin
         rnd   = {$urandom, $urandom, $urandom, $urandom};
         junk  = $urandom;
         ef[j] = rnd[104:0];
         ws[j] = {{junk[31:9], rnd[104:96]}, rnd[95:64], rnd[63:32], rnd[31:0]};
      end
      fork
         writer6(ws);
         begin
            tb_fields_t   d;
            logic [104:0] prev_instr;
            logic         prev_hold;
            int           got;
            int           cyc;
            got = 0; cyc = 0; prev_hold = 1'b0; prev_instr = '0;
            while (got < N6 && cyc < 4000) begin
               @(negedge clk);
               cyc++;
               if (prev_hold) chk("t6_stable", instr, prev_instr);
               instr_ready = ($urandom_range(0, 2) != 0);
               if (instr_valid && instr_ready) begin
                  d = instr;
                  chk("t6_instr", d, ef[got]);
                  chk("t6_a_addr", d.a_addr, ef[got].a_addr);
                  got++;
               end
               prev_hold  = instr_valid && !instr_ready;
               prev_instr = instr;
            end
            @(negedge clk);
            instr_ready = 1'b0;
            if (got < N6) begin
               n_vec++;
               n_miss++;
               $display("FAIL t6_timeout: got %0d instrs expected %0d", got, N6);
            end
         end
      join
      chk("t6_count_end", fifo_count, 0);
      chk("t6_busy_end", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
